// File: rtl/bit_field_reader.sv
`default_nettype none
// ============================================================================
// Module   : bit_field_reader
// Purpose  : Pulls MSB-first 0..MAX_LEN bit fields from a one-bit FIFO and
//            returns each one right-aligned. BIT_FIELD_READER_CRC_EN adds a
//            running CRC-16 (poly 0x8005) over every consumed bit.
// Revision : 1.0 - initial release
// ============================================================================
module bit_field_reader #(
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = 16,
  localparam int LW     = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               req_valid,
  input  logic [LW-1:0]      req_len,
  input  logic               req_skip,
  output logic               req_ready,
  output logic               fifo_rd_en,
  input  logic               fifo_bit,
  input  logic [CNT_W-1:0]   fifo_count,
  output logic               field_valid,
  output logic [MAX_LEN-1:0] field_data,
  output logic               busy,
  output logic [31:0]        bits_consumed,
  input  logic               crc_clear,
  output logic [15:0]        crc_value
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LW-1:0] c_MAX_LEN = LW'(MAX_LEN);
  localparam logic [LW-1:0] c_ONE     = LW'(1);

  state_t             r_state;
  logic [LW-1:0]      r_len;
  logic [LW-1:0]      r_issued;
  logic               r_skip;
  logic               r_prev_rd_en;
  logic [MAX_LEN-2:0] r_shreg;

  logic [LW-1:0]      w_len;
  logic               w_can_accept;
  logic               w_active;
  logic               w_bit_in;
  logic [MAX_LEN-1:0] w_shreg_next;

  assign w_len        = (req_len > c_MAX_LEN) ? c_MAX_LEN : req_len;
  // DONE also accepts a request so back-to-back fields lose no cycle.
  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_active     = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_bit_in     = w_active && r_prev_rd_en && !flush;
  assign w_shreg_next = {r_shreg, fifo_bit};

  assign req_ready    = w_can_accept;
  assign busy         = w_active;
  assign field_valid  = (r_state == S_DONE);
  // The upstream count lags a pop by one cycle, so discount last cycle's pop.
  assign fifo_rd_en   = (r_state == S_FETCH) && !flush && (r_issued < r_len) &&
                        (fifo_count > CNT_W'(r_prev_rd_en));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_issued      <= '0;
      r_skip        <= 1'b0;
      r_prev_rd_en  <= 1'b0;
      r_shreg       <= '0;
      field_data    <= '0;
      bits_consumed <= '0;
    end else begin
      r_prev_rd_en <= fifo_rd_en;
      if (w_bit_in) begin
        r_shreg       <= w_shreg_next[MAX_LEN-2:0];
        bits_consumed <= bits_consumed + 32'd1;
      end
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            r_state <= S_IDLE;
            if (req_valid) begin
              r_len    <= w_len;
              r_skip   <= req_skip;
              r_issued <= '0;
              r_shreg  <= '0;
              if (w_len == '0) begin
                r_state <= S_DONE;
                if (!req_skip) field_data <= '0;
              end else begin
                r_state <= S_FETCH;
              end
            end
          end
          S_FETCH: begin
            if (fifo_rd_en) begin
              r_issued <= r_issued + c_ONE;
              if (r_issued == r_len - c_ONE) r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (r_prev_rd_en) begin
              r_state <= S_DONE;
              if (!r_skip) field_data <= w_shreg_next;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef BIT_FIELD_READER_CRC_EN
  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb      = r_crc[15] ^ fifo_bit;
  assign crc_value = r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 16'hFFFF;
    end else if (crc_clear) begin
      r_crc <= 16'hFFFF;
    end else if (w_bit_in) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h8005 : 16'h0000);
    end
  end
`else
  logic w_unused_crc_clear;

  assign w_unused_crc_clear = crc_clear;
  assign crc_value          = 16'hFFFF;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_field_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_field_reader
// Purpose  : Directed self-checking bench for bit_field_reader with a
//            lagging-count one-bit FIFO model upstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_field_reader;

  localparam int MAX_LEN = 32;
  localparam int CNT_W   = 16;
  localparam int LW      = 6;
`ifdef BIT_FIELD_READER_CRC_EN
  localparam logic [15:0] C_CRC_EXP = 16'hAEE7;
`else
  localparam logic [15:0] C_CRC_EXP = 16'hFFFF;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               req_valid = 1'b0;
  logic [LW-1:0]      req_len = '0;
  logic               req_skip = 1'b0;
  logic               fifo_bit = 1'b0;
  logic [CNT_W-1:0]   fifo_count = '0;
  logic               crc_clear = 1'b0;
  logic               req_ready;
  logic               fifo_rd_en;
  logic               field_valid;
  logic [MAX_LEN-1:0] field_data;
  logic               busy;
  logic [31:0]        bits_consumed;
  logic [15:0]        crc_value;

  int n_cmp  = 0;
  int n_fail = 0;

  bit_field_reader #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid),
    .req_len(req_len), .req_skip(req_skip), .req_ready(req_ready),
    .fifo_rd_en(fifo_rd_en), .fifo_bit(fifo_bit), .fifo_count(fifo_count),
    .field_valid(field_valid), .field_data(field_data), .busy(busy),
    .bits_consumed(bits_consumed), .crc_clear(crc_clear), .crc_value(crc_value)
  );

  always #5 clk = ~clk;

  // Upstream FIFO: bit valid one cycle after the pop, count a cycle behind that.
  bit q[$];
  int sz_d      = 0;
  int underflow = 0;
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (q.size() > 0) fifo_bit <= q.pop_front();
      else underflow++;
    end
    fifo_count <= CNT_W'(sz_d);
    sz_d = q.size();
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  task automatic drop_q();
    q.delete();
    settle();
  endtask

  task automatic start_req(input int len, input logic skip);
    tick();
    req_valid = 1'b1;
    req_len   = LW'(len);
    req_skip  = skip;
    tick();
    req_valid = 1'b0;
    req_skip  = 1'b0;
  endtask

  // Index c=0 is the cycle the task is entered in; stops on field_valid.
  task automatic watch(input int budget, output logic [63:0] mask, output int npop, output int fvc);
    mask = '0;
    npop = 0;
    fvc  = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        npop++;
        if (c < 64) mask[c] = 1'b1;
      end
      if (field_valid) begin
        fvc = c;
        break;
      end
      tick();
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({pfx, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
    chk({pfx, "_field_valid"}, 64'(field_valid), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_field_data"}, 64'(field_data), 64'd0);
    chk({pfx, "_bits"}, 64'(bits_consumed), 64'd0);
    chk({pfx, "_crc"}, 64'(crc_value), 64'hFFFF);
  endtask

  initial begin
    logic [63:0] m;
    int np;
    int fv;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // 8-bit field 0xB1 on a full FIFO.
    push(64'hB1, 8);
    settle();
    start_req(8, 1'b0);
    watch(20, m, np, fv);
    chk("len8_rd_en_cycles", m, 64'hFF);
    chk("len8_fv_cycle", 64'(fv), 64'd9);
    chk("len8_data", 64'(field_data), 64'hB1);
    chk("len8_bits", 64'(bits_consumed), 64'd8);
    chk("len8_ready_at_done", 64'(req_ready), 64'd1);

    // Skip 12 bits: data holds.
    push(64'hFFF, 12);
    settle();
    start_req(12, 1'b1);
    watch(30, m, np, fv);
    chk("skip_pops", 64'(np), 64'd12);
    chk("skip_fv_cycle", 64'(fv), 64'd13);
    chk("skip_data_held", 64'(field_data), 64'hB1);
    chk("skip_bits", 64'(bits_consumed), 64'd20);

    // Zero-length field.
    start_req(0, 1'b0);
    watch(5, m, np, fv);
    chk("len0_fv_cycle", 64'(fv), 64'd0);
    chk("len0_pops", 64'(np), 64'd0);
    chk("len0_data", 64'(field_data), 64'd0);
    chk("len0_bits", 64'(bits_consumed), 64'd20);

    // Over-long request clamps to 32.
    push(64'hDEADBEEF00, 40);
    settle();
    start_req(40, 1'b0);
    watch(60, m, np, fv);
    chk("len40_pops", 64'(np), 64'd32);
    chk("len40_fv_cycle", 64'(fv), 64'd33);
    chk("len40_data", 64'(field_data), 64'hDEADBEEF);
    chk("len40_bits", 64'(bits_consumed), 64'd52);
    chk("len40_left_in_fifo", 64'(q.size()), 64'd8);
    drop_q();

    // Stall on an underfilled FIFO, then resume.
    push(64'b101, 3);
    settle();
    start_req(5, 1'b0);
    watch(8, m, np, fv);
    chk("stall_pops", 64'(np), 64'd3);
    chk("stall_no_fv", 64'(fv), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_not_ready", 64'(req_ready), 64'd0);
    push(64'b11, 2);
    watch(12, m, np, fv);
    chk("resume_pops", 64'(np), 64'd2);
    chk("resume_fv_cycle", 64'(fv), 64'd5);
    chk("resume_data", 64'(field_data), 64'h17);
    chk("resume_bits", 64'(bits_consumed), 64'd57);

    // Flush in the cycle after the third pop.
    push(64'hFF, 8);
    settle();
    start_req(8, 1'b0);
    watch(3, m, np, fv);
    chk("flush_pre_pops", 64'(np), 64'd3);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_no_fv", 64'(field_valid), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_idle_ready", 64'(req_ready), 64'd1);
    chk("flush_idle_busy", 64'(busy), 64'd0);
    chk("flush_bits", 64'(bits_consumed), 64'd59);
    chk("flush_data_held", 64'(field_data), 64'h17);
    watch(5, m, np, fv);
    chk("flush_after_pops", 64'(np), 64'd0);
    chk("flush_after_no_fv", 64'(fv), 64'hFFFF_FFFF_FFFF_FFFF);
    drop_q();

    // Asynchronous reset mid-FETCH.
    push(64'hFF, 8);
    settle();
    start_req(8, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    drop_q();

    // CRC over "123456789" read as three 24-bit fields.
    crc_clear = 1'b1;
    tick();
    crc_clear = 1'b0;
    push(64'h313233, 24);
    push(64'h343536, 24);
    push(64'h373839, 24);
    settle();
    start_req(24, 1'b0);
    watch(40, m, np, fv);
    chk("crc_f1_data", 64'(field_data), 64'h313233);
    start_req(24, 1'b0);
    watch(40, m, np, fv);
    chk("crc_f2_data", 64'(field_data), 64'h343536);
    start_req(24, 1'b0);
    watch(40, m, np, fv);
    chk("crc_f3_data", 64'(field_data), 64'h373839);
    chk("crc_bits", 64'(bits_consumed), 64'd72);
    chk("crc_value", 64'(crc_value), 64'(C_CRC_EXP));
    chk("fifo_underflow", 64'(underflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
